serial_sub: RTL and testbench

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_sub.sv | 128 ++++++++++++
 tb/tb_serial_sub.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor computing {Bout, D} = A - B - Bin.
// One full-subtractor and a borrow flip-flop handle one bit per clock, LSB
// first. The minuend register doubles as the difference register: each
// result bit is shifted in at the top as the operand bit drops out below.
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH:0]   Q,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic diff_bit;
    logic borrow_next;
    logic last_bit;
    logic load;
    logic step;
    logic busy_next;
    logic done_next;

    // Full-subtractor on the current LSBs plus the running borrow
    always_comb begin
        diff_bit    = a_reg[0] ^ b_reg[0] ^ borrow;
        borrow_next = (~a_reg[0] & (b_reg[0] | borrow)) | (b_reg[0] & borrow);
        last_bit    = (cnt == LAST);
    end

    // Next-state and control decode; enable is only honoured from IDLE
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    load       = 1'b1;
                    busy_next  = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (last_bit) begin
                    done_next  = 1'b1;
                    state_next = DONE;
                end else begin
                    busy_next = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered status flags so busy and done are glitch-free outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_next;
            done <= done_next;
        end
    end

    // Operand capture, serial shifting and result load on the final bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            Q      <= '0;
        end else if (load) begin
            a_reg  <= A;
            b_reg  <= B;
            borrow <= Bin;
            cnt    <= '0;
        end else if (step) begin
            a_reg  <= {diff_bit, a_reg[WIDTH-1:1]};
            b_reg  <= b_reg >> 1;
            borrow <= borrow_next;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                Q <= {borrow_next, diff_bit, a_reg[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed test of serial_sub at WIDTH=4 with hand-computed
// expected results for each scenario.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [3:0] A;
    logic [3:0] B;
    logic       Bin;
    logic [4:0] Q;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    serial_sub #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .A       (A),
        .B       (B),
        .Bin     (Bin),
        .Q       (Q),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with enable for exactly one load edge
    task automatic start_op(input logic [3:0] a, input logic [3:0] b, input logic bin);
        A = a;
        B = b;
        Bin = bin;
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    // Wait (bounded) for done; returns edges after the load edge, or -1
    task automatic wait_done(output logic [4:0] q, output int lat);
        lat = -1;
        q = 'x;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin
                lat = i;
                q = Q;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable = 1'b0;
        A = 4'b1010;
        B = 4'b0101;
        Bin = 1'b1;
        tick();
        tick();
        checks++; if (Q !== 5'b00000) begin errors++; $display("[TB] FAIL reset_q: got %b expected %b", Q, 5'b00000); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        A = 4'b0101;
        B = 4'b0001;
        Bin = 1'b0;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL basic_load_flags: got busy=%b done=%b expected busy=1 done=0", busy, done); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL basic_shift_flags edge %0d: got busy=%b done=%b expected busy=1 done=0", i, busy, done); end
        end
        tick();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_flags: got busy=%b done=%b expected busy=0 done=1", busy, done); end
        checks++; if (Q !== 5'b00100) begin errors++; $display("[TB] FAIL basic_q: got %b expected %b", Q, 5'b00100); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_after_done: got busy=%b done=%b expected busy=0 done=0", busy, done); end
        checks++; if (Q !== 5'b00100) begin errors++; $display("[TB] FAIL basic_q_hold: got %b expected %b", Q, 5'b00100); end
    endtask

    task automatic test_zero_borrow();
        logic [3:0] av [2] = '{4'b0111, 4'b1000};
        logic [3:0] bv [2] = '{4'b0111, 4'b0111};
        logic       cv [2] = '{1'b0, 1'b1};
        logic [4:0] ev [2] = '{5'b00000, 5'b00000};
        logic [4:0] q;
        int lat;
        for (int i = 0; i < 2; i++) begin
            start_op(av[i], bv[i], cv[i]);
            wait_done(q, lat);
            checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL zero_latency %0d: got %0d expected 4", i, lat); end
            checks++; if (q !== ev[i]) begin errors++; $display("[TB] FAIL zero_q %0d: got %b expected %b", i, q, ev[i]); end
        end
    endtask

    task automatic test_wraparound();
        logic [3:0] av [3] = '{4'b0100, 4'b1111, 4'b0000};
        logic [3:0] bv [3] = '{4'b1100, 4'b1111, 4'b0000};
        logic       cv [3] = '{1'b0, 1'b0, 1'b1};
        logic [4:0] ev [3] = '{5'b11000, 5'b00000, 5'b11111};
        logic [4:0] q;
        int lat;
        for (int i = 0; i < 3; i++) begin
            start_op(av[i], bv[i], cv[i]);
            wait_done(q, lat);
            checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL wrap_latency %0d: got %0d expected 4", i, lat); end
            checks++; if (q !== ev[i]) begin errors++; $display("[TB] FAIL wrap_q %0d: got %b expected %b", i, q, ev[i]); end
        end
    endtask

    task automatic test_idle_hold();
        int stray = 0;
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            A = 4'(i * 3);
            B = 4'(i + 7);
            Bin = i[0];
            tick();
            if (busy || done || Q !== 5'b11111) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL idle_hold: got %0d disturbed cycles expected 0 (Q=%b)", stray, Q); end
    endtask

    task automatic test_busy_protect();
        int dones = 0;
        int done_edge = -1;
        int late_busy = 0;
        logic [4:0] q = 'x;
        start_op(4'b1001, 4'b0010, 1'b0);
        A = 4'b0000;
        B = 4'b0001;
        Bin = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (done) begin
                dones++;
                done_edge = i;
                q = Q;
            end
            if (i >= 6 && busy) late_busy++;
            if (i == 5) enable = 1'b0;
        end
        checks++; if (dones !== 1) begin errors++; $display("[TB] FAIL protect_done_count: got %0d expected 1", dones); end
        checks++; if (done_edge !== 4) begin errors++; $display("[TB] FAIL protect_done_edge: got %0d expected 4", done_edge); end
        checks++; if (q !== 5'b00111) begin errors++; $display("[TB] FAIL protect_q: got %b expected %b", q, 5'b00111); end
        checks++; if (late_busy !== 0) begin errors++; $display("[TB] FAIL protect_restart: got %0d busy cycles expected 0", late_busy); end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        logic [4:0] q;
        int lat;
        start_op(4'b1001, 4'b1010, 1'b1);
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midreset_busy_before: got %b expected 1", busy); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (Q !== 5'b00000) begin errors++; $display("[TB] FAIL midreset_q: got %b expected %b", Q, 5'b00000); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_flags: got busy=%b done=%b expected busy=0 done=0", busy, done); end
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("[TB] FAIL midreset_no_done: got %0d active cycles expected 0", dones); end
        checks++; if (Q !== 5'b00000) begin errors++; $display("[TB] FAIL midreset_q_after: got %b expected %b", Q, 5'b00000); end
        start_op(4'b0110, 4'b0011, 1'b0);
        wait_done(q, lat);
        checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL midreset_restart_latency: got %0d expected 4", lat); end
        checks++; if (q !== 5'b00011) begin errors++; $display("[TB] FAIL midreset_restart_q: got %b expected %b", q, 5'b00011); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] av [3] = '{4'd3, 4'd10, 4'd6};
        logic [3:0] bv [3] = '{4'd5, 4'd3, 4'd6};
        logic       cv [3] = '{1'b0, 1'b1, 1'b1};
        logic [4:0] ev [3] = '{5'b11110, 5'b00110, 5'b11111};
        int loads = 0;
        int dones = 0;
        int last_done = -1;
        int overlap = 0;
        logic prev_busy = 1'b0;
        A = av[0];
        B = bv[0];
        Bin = cv[0];
        enable = 1'b1;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (busy && done) overlap++;
            if (busy && !prev_busy) begin
                loads++;
                if (loads < 3) begin
                    A = av[loads];
                    B = bv[loads];
                    Bin = cv[loads];
                end else begin
                    enable = 1'b0;
                    A = 4'hF;
                    B = 4'h0;
                    Bin = 1'b0;
                end
            end
            if (done) begin
                if (dones < 3) begin
                    checks++; if (Q !== ev[dones]) begin errors++; $display("[TB] FAIL b2b_q %0d: got %b expected %b", dones, Q, ev[dones]); end
                end
                if (dones > 0) begin
                    checks++; if (c - last_done !== 6) begin errors++; $display("[TB] FAIL b2b_spacing %0d: got %0d expected 6", dones, c - last_done); end
                end
                last_done = c;
                dones++;
            end
            prev_busy = busy;
        end
        enable = 1'b0;
        checks++; if (loads !== 3) begin errors++; $display("[TB] FAIL b2b_loads: got %0d expected 3", loads); end
        checks++; if (dones !== 3) begin errors++; $display("[TB] FAIL b2b_dones: got %0d expected 3", dones); end
        checks++; if (overlap !== 0) begin errors++; $display("[TB] FAIL b2b_busy_done_overlap: got %0d expected 0", overlap); end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_basic();
        tick();
        test_zero_borrow();
        test_wraparound();
        test_idle_hold();
        test_busy_protect();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
